// File: rtl/toy_bus_mst_arb.sv
// toy_bus_mst_arb
// Merges the instruction-fetch requester (r0) and the LSU requester (r1) onto
// the single toy_bus master port. The request path is combinational. The grant
// is held ("locked") while the bus stalls a presented request. A small order
// FIFO of requester IDs routes each in-order ack back to the requester that
// issued the matching request.
//
// Optional feature (compile-time macro TOY_BUS_ARB_QOS_EN):
//   defined   : the LSU has fixed priority over fetch. A starvation counter
//               hands the next grant to fetch after 4 LSU grants taken while
//               fetch was waiting.
//   undefined : two-way round robin, fetch first after reset.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rN_req_*  (N=0,1)          requester request channel (vld/rdy + payload)
//   rN_ack_*  (N=0,1)          ack channel back to requester N
//   m_req_*                    muxed request to the bus master port
//   m_ack_*                    ack from the bus (in request order)
//   ost_cnt                    number of outstanding requests
module toy_bus_mst_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SB_WIDTH   = 32,
  parameter int OST_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        r0_req_vld,
  output logic                        r0_req_rdy,
  input  logic [ADDR_WIDTH-1:0]       r0_req_addr,
  input  logic [DATA_WIDTH-1:0]       r0_req_data,
  input  logic [DATA_WIDTH/8-1:0]     r0_req_strb,
  input  logic                        r0_req_opcode,
  input  logic [SB_WIDTH-1:0]         r0_req_sideband,
  output logic                        r0_ack_vld,
  input  logic                        r0_ack_rdy,
  output logic [DATA_WIDTH-1:0]       r0_ack_data,
  output logic [SB_WIDTH-1:0]         r0_ack_sideband,

  input  logic                        r1_req_vld,
  output logic                        r1_req_rdy,
  input  logic [ADDR_WIDTH-1:0]       r1_req_addr,
  input  logic [DATA_WIDTH-1:0]       r1_req_data,
  input  logic [DATA_WIDTH/8-1:0]     r1_req_strb,
  input  logic                        r1_req_opcode,
  input  logic [SB_WIDTH-1:0]         r1_req_sideband,
  output logic                        r1_ack_vld,
  input  logic                        r1_ack_rdy,
  output logic [DATA_WIDTH-1:0]       r1_ack_data,
  output logic [SB_WIDTH-1:0]         r1_ack_sideband,

  output logic                        m_req_vld,
  input  logic                        m_req_rdy,
  output logic [ADDR_WIDTH-1:0]       m_req_addr,
  output logic [DATA_WIDTH-1:0]       m_req_data,
  output logic [DATA_WIDTH/8-1:0]     m_req_strb,
  output logic                        m_req_opcode,
  output logic [SB_WIDTH-1:0]         m_req_sideband,
  input  logic                        m_ack_vld,
  output logic                        m_ack_rdy,
  input  logic [DATA_WIDTH-1:0]       m_ack_data,
  input  logic [SB_WIDTH-1:0]         m_ack_sideband,

  output logic [$clog2(OST_DEPTH+1)-1:0] ost_cnt
);

  localparam int CW = $clog2(OST_DEPTH+1);
  localparam int PW = $clog2(OST_DEPTH);

  logic [OST_DEPTH-1:0] r_ord;      // requester ID per FIFO slot
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_lock;
  logic                 r_lock_id;

  logic w_any_vld;
  logic w_full;
  logic w_empty;
  logic w_pick;
  logic w_gnt;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_any_vld = r0_req_vld | r1_req_vld;
  assign w_full    = (r_cnt == CW'(OST_DEPTH));
  assign w_empty   = (r_cnt == '0);

`ifdef TOY_BUS_ARB_QOS_EN
  logic [2:0] r_starve;

  // LSU wins unless fetch has been passed over 4 times while waiting.
  assign w_pick = (r_starve >= 3'd4 && r0_req_vld) ? 1'b0 : r1_req_vld;
`else
  logic r_rr_ptr;

  // First valid requester at or after the round-robin pointer.
  assign w_pick = r_rr_ptr ? r1_req_vld : ~r0_req_vld;
`endif

  // A stalled request keeps its grant so the bus sees a stable payload.
  assign w_gnt = r_lock ? r_lock_id : w_pick;

  assign m_req_vld      = w_any_vld & ~w_full;
  assign m_req_addr     = w_gnt ? r1_req_addr     : r0_req_addr;
  assign m_req_data     = w_gnt ? r1_req_data     : r0_req_data;
  assign m_req_strb     = w_gnt ? r1_req_strb     : r0_req_strb;
  assign m_req_opcode   = w_gnt ? r1_req_opcode   : r0_req_opcode;
  assign m_req_sideband = w_gnt ? r1_req_sideband : r0_req_sideband;

  assign r0_req_rdy = m_req_vld & m_req_rdy & ~w_gnt;
  assign r1_req_rdy = m_req_vld & m_req_rdy &  w_gnt;

  assign w_push = m_req_vld & m_req_rdy;

  // Ack routing: the oldest outstanding request owns the ack channel.
  assign w_head    = r_ord[r_rd_ptr];
  assign m_ack_rdy = ~w_empty & (w_head ? r1_ack_rdy : r0_ack_rdy);
  assign w_pop     = m_ack_vld & m_ack_rdy;

  assign r0_ack_vld      = ~w_empty & m_ack_vld & ~w_head;
  assign r1_ack_vld      = ~w_empty & m_ack_vld &  w_head;
  assign r0_ack_data     = m_ack_data;
  assign r1_ack_data     = m_ack_data;
  assign r0_ack_sideband = m_ack_sideband;
  assign r1_ack_sideband = m_ack_sideband;

  assign ost_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ord     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      if (w_push) begin
        r_ord[r_wr_ptr] <= w_gnt;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

      if (w_push) begin
        r_lock <= 1'b0;
      end else if (m_req_vld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt;
      end
    end
  end

`ifdef TOY_BUS_ARB_QOS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_push) begin
      if (!w_gnt) begin
        r_starve <= '0;
      end else if (r0_req_vld && r_starve != 3'd7) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_push) begin
      r_rr_ptr <= ~w_gnt;
    end
  end
`endif

endmodule
